axi_lite_sram_slave: RTL and testbench
======================================

# axi_lite_sram_slave

AXI4-Lite responder fronting a single-port, byte-writable word RAM; it serves as the memory the CPU's AXI-Lite master talks to in the system-level bench and the FPGA top. It accepts AW/W/AR independently, arbitrates write commits and reads onto the one RAM port round-robin, and returns OKAY or SLVERR responses. It issues no interrupts and holds no configuration registers.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, 16..65536.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: reset, synchronous, active-high.
- `axi_awaddr` input 32, `axi_awvalid` input 1, `axi_awready` output 1, `axi_awprot` input 3: write address channel; prot ignored.
- `axi_wdata` input 32, `axi_wstrb` input 4, `axi_wvalid` input 1, `axi_wready` output 1: write data channel.
- `axi_bresp` output 2, `axi_bvalid` output 1, `axi_bready` input 1: write response channel.
- `axi_araddr` input 32, `axi_arvalid` input 1, `axi_arready` output 1, `axi_arprot` input 3: read address channel; prot ignored.
- `axi_rdata` output 32, `axi_rresp` output 2, `axi_rvalid` output 1, `axi_rready` input 1: read data channel.

## Operation
- Decode: offset = addr − BASE_ADDR (32-bit wrap); in range iff offset < DEPTH*4. Word index = offset[log2(DEPTH)+1:2]; addr[1:0] ignored.
- Write path: one holding register each for AW and W. awready = !aw_held; wready = !w_held. Both may handshake in the same cycle or in either order.
- Write commit: occurs when aw_held && w_held && (!bvalid || bready) && write granted. In range: bytes with wstrb set are written, bresp=OKAY. Out of range: RAM untouched, bresp=SLVERR. Commit clears both holds and loads bvalid=1 next cycle. bvalid/bresp stay stable until bready.
- wstrb=4'b0000 in range: commit with no byte change, OKAY.
- Read FSM:
  - R_IDLE: arready=1. AR handshake latches the address and moves to R_READ.
  - R_READ: waits for the RAM grant. RAM is read on the grant cycle, then the FSM moves to R_RESP.
  - R_RESP: rvalid=1 with rdata/rresp stable until rready, then back to R_IDLE. arready=0 outside R_IDLE.
  - Out of range: rdata=0, rresp=SLVERR, RAM port not requested.
- Arbitration: conflict occurs when a write commit is eligible and R_READ (in range) is active in the same cycle. The requester not granted last conflict wins. The `last_grant` bit resets to read, so the first conflict favours write. The loser retries next cycle. Uncontested requests are granted immediately and do not update `last_grant`.
- Ordering: same-address read/write order follows grant order. No forwarding.
- Reset: holds, FSM and `last_grant` are cleared. In-flight transactions are dropped with no response. Uncommitted writes are lost. RAM contents are not reset.

## Timing
- While rst=1: awready, wready, arready, bvalid and rvalid are all 0; bresp=0, rresp=0, rdata=0. In the first cycle after rst deasserts: awready=1, wready=1, arready=1.
- Write: AW+W handshake in cycle N → commit in N+1 → bvalid in N+2 (uncontested, B channel free). If W handshakes k cycles after AW, bvalid is at N+k+2.
- Read: AR handshake in N → RAM read in N+1 → rvalid in N+2 (uncontested). Each lost arbitration adds 1 cycle.
- Throughput: one outstanding read. Back-to-back read issue rate is one per 3 cycles with rready held high. Writes can sustain one per 2 cycles with bready held high.
- Backpressure: bready low blocks further commits; the holds fill and awready/wready drop. rready low holds R_RESP.

## Structure
- Package `axi_lite_pkg`: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the read state enum (R_IDLE, R_READ, R_RESP).
- Sub-module `axi_sram_sp`: single-port RAM with DEPTH×32 storage, 4 byte-enables, registered read data and one address port, inferable as block RAM. The top instantiates it once.

## Test plan
- Reset mid-write: AW handshake then rst pulse, no W → bvalid never rises; awready=1 and wready=1 one cycle after rst falls.
- Single write and readback: write 0xDEADBEEF to 0x10 with wstrb=4'hF, then write 0x000000AA with wstrb=4'h1 → bresp=OKAY at N+2; read 0x10 → rvalid at N+2, rdata=0xDEADBEAA, rresp=OKAY.
- Split AW/W: W handshakes 3 cycles before AW → bvalid 2 cycles after AW; bready held low 5 cycles → awready=0 and wready=0 after a second AW/W pair, and the second bvalid follows 1 cycle after the first B handshake.
- Out of range: write and read at BASE_ADDR+DEPTH*4 → bresp=SLVERR, rresp=SLVERR, rdata=0; a later read of word 0 shows it unchanged.
- Conflict: write to 0x20 committing in the same cycle as an in-range R_READ on 0x20 (old 0x1, new 0x2). First conflict → write wins, read returns 0x2. Next conflict → read wins.
- Backpressure: rready low 4 cycles → rdata/rresp stable, arready=0 throughout; arready=1 the cycle after the R handshake.

Source files
------------

// File: rtl/axi_lite_sram_slave_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// read-channel state encoding, arbitration tags and the address decode helper.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Read channel FSM states
    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_READ = 2'b01,
        R_RESP = 2'b10
    } rd_state_e;

    // Tags for the round-robin arbiter's memory of the last conflict winner
    localparam logic GRANT_READ  = 1'b0;
    localparam logic GRANT_WRITE = 1'b1;

    // True when addr falls inside [base, base+span), with 32-bit wrap so that
    // addresses below base land far above span and decode as out of range.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] span);
        logic [31:0] offset;
        offset = addr - base;
        return (offset < span);
    endfunction

endpackage

// File: rtl/axi_lite_sram_slave_sram_sp.sv
// Single-port DEPTH x 32 RAM with per-byte write enables and a registered
// read port. Written so synthesis maps it onto block RAM: no reset on the
// array or on the read register. The read register only updates on read
// cycles, so a pending read result survives intervening writes.
module axi_sram_sp #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       be_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-masked write or registered read on the single port
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite responder in front of a single-port byte-writable RAM.
// AW and W are captured in independent holding registers; a write commits
// once both are held and the B channel can take the response. Reads run
// through a three-state FSM with one outstanding transaction. Write commits
// and in-range reads share the RAM port under round-robin arbitration.
module axi_lite_sram_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

    // Ready outputs stay low until the first cycle after reset is released
    logic             alive_q;

    // Write holding registers (address already decoded to index + range flag)
    logic             aw_held_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic             aw_inr_q;
    logic             w_held_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wstrb_q;

    // Write response
    logic             bvalid_q;
    logic [1:0]       bresp_q;

    // Read channel
    rd_state_e        rd_state_q;
    rd_state_e        rd_state_d;
    logic [IDX_W-1:0] rd_idx_q;
    logic             rd_inr_q;

    // Arbiter memory: who won the most recent conflict
    logic             last_grant_q;

    logic [31:0]      aw_off_s;
    logic [31:0]      ar_off_s;
    logic             aw_hs_s;
    logic             w_hs_s;
    logic             ar_hs_s;
    logic             wr_elig_s;
    logic             rd_req_s;
    logic             conflict_s;
    logic             wr_grant_s;
    logic             rd_grant_s;
    logic             ram_en_s;
    logic             ram_we_s;
    logic [IDX_W-1:0] ram_addr_s;
    logic [31:0]      ram_rdata_s;
    logic             unused_s;

    assign aw_off_s = axi_awaddr - BASE_ADDR;
    assign ar_off_s = axi_araddr - BASE_ADDR;

    assign axi_awready = alive_q && !aw_held_q;
    assign axi_wready  = alive_q && !w_held_q;
    assign axi_arready = alive_q && (rd_state_q == R_IDLE);

    assign aw_hs_s = axi_awvalid && axi_awready;
    assign w_hs_s  = axi_wvalid  && axi_wready;
    assign ar_hs_s = axi_arvalid && axi_arready;

    // A commit is eligible once both halves are held and B has room
    assign wr_elig_s  = aw_held_q && w_held_q && (!bvalid_q || axi_bready);
    // Out-of-range reads never touch the RAM port
    assign rd_req_s   = (rd_state_q == R_READ) && rd_inr_q;
    assign conflict_s = wr_elig_s && rd_req_s;

    // Round-robin grant: on conflict the side that lost last time wins
    always_comb begin
        wr_grant_s = 1'b0;
        rd_grant_s = 1'b0;
        if (conflict_s) begin
            if (last_grant_q == GRANT_READ) begin
                wr_grant_s = 1'b1;
            end else begin
                rd_grant_s = 1'b1;
            end
        end else begin
            wr_grant_s = wr_elig_s;
            rd_grant_s = rd_req_s;
        end
    end

    // RAM port steering: an out-of-range commit leaves the RAM idle
    always_comb begin
        ram_we_s   = wr_grant_s && aw_inr_q;
        ram_en_s   = ram_we_s || rd_grant_s;
        ram_addr_s = rd_idx_q;
        if (ram_we_s) begin
            ram_addr_s = aw_idx_q;
        end else begin
            ram_addr_s = rd_idx_q;
        end
    end

    // Ready-enable flag released one cycle after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    // AW holding register: filled on handshake, emptied on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_inr_q  <= 1'b0;
        end else if (wr_grant_s) begin
            aw_held_q <= 1'b0;
        end else if (aw_hs_s) begin
            aw_held_q <= 1'b1;
            aw_idx_q  <= aw_off_s[IDX_W+1:2];
            aw_inr_q  <= addr_in_range(axi_awaddr, BASE_ADDR, SPAN);
        end
    end

    // W holding register: filled on handshake, emptied on commit
    always_ff @(posedge clk) begin
        if (rst) begin
            w_held_q <= 1'b0;
            wdata_q  <= 32'h0000_0000;
            wstrb_q  <= 4'b0000;
        end else if (wr_grant_s) begin
            w_held_q <= 1'b0;
        end else if (w_hs_s) begin
            w_held_q <= 1'b1;
            wdata_q  <= axi_wdata;
            wstrb_q  <= axi_wstrb;
        end
    end

    // B channel: a commit loads a fresh response, bready retires it
    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_grant_s) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_inr_q ? RESP_OKAY : RESP_SLVERR;
        end else if (axi_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read FSM next-state logic
    always_comb begin
        rd_state_d = rd_state_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs_s) begin
                    rd_state_d = R_READ;
                end else begin
                    rd_state_d = R_IDLE;
                end
            end
            R_READ: begin
                if (!rd_inr_q || rd_grant_s) begin
                    rd_state_d = R_RESP;
                end else begin
                    rd_state_d = R_READ;
                end
            end
            R_RESP: begin
                if (axi_rready) begin
                    rd_state_d = R_IDLE;
                end else begin
                    rd_state_d = R_RESP;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Read FSM state and latched read address
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_inr_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs_s) begin
                rd_idx_q <= ar_off_s[IDX_W+1:2];
                rd_inr_q <= addr_in_range(axi_araddr, BASE_ADDR, SPAN);
            end
        end
    end

    // Remember the conflict winner; uncontested grants leave it alone
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_READ;
        end else if (conflict_s) begin
            last_grant_q <= wr_grant_s ? GRANT_WRITE : GRANT_READ;
        end
    end

    axi_sram_sp #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (wdata_q),
        .be_i    (wstrb_q),
        .rdata_o (ram_rdata_s)
    );

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = (rd_state_q == R_RESP);
    assign axi_rresp  = ((rd_state_q == R_RESP) && !rd_inr_q) ? RESP_SLVERR : RESP_OKAY;
    // RAM read register only changes on read cycles, so it is stable in R_RESP
    assign axi_rdata  = ((rd_state_q == R_RESP) && rd_inr_q) ? ram_rdata_s : 32'h0000_0000;

    assign unused_s = ^{axi_awprot, axi_arprot,
                        aw_off_s[31:IDX_W+2], aw_off_s[1:0],
                        ar_off_s[31:IDX_W+2], ar_off_s[1:0]};

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Self-checking bench for axi_lite_sram_slave. Expected values come from a
// word-array memory model and from latency/ordering rules computed here.
module tb_axi_lite_sram_slave;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] SPAN  = 32'(DEPTH * 4);
    localparam logic [31:0] OOR   = 32'h0000_1000;
    localparam logic [1:0]  OKAY  = 2'b00;
    localparam logic [1:0]  SLV   = 2'b10;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [int];

    always #5 clk = ~clk;

    axi_lite_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] off;
        logic [31:0] w;
        int idx;
        off = a - BASE;
        if (off < SPAN) begin
            idx = int'(off >> 2);
            w = model.exists(idx) ? model[idx] : 32'h0;
            for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
            model[idx] = w;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] off;
        int idx;
        off = a - BASE;
        idx = int'(off >> 2);
        if (off < SPAN && model.exists(idx)) return model[idx];
        return 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return ((a - BASE) < SPAN) ? OKAY : SLV;
    endfunction

    // Full write transaction; lat = cycles from last AW/W handshake to bvalid
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done = 0;
        int n = 0;
        axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            if (axi_awvalid && axi_awready) aw_done = 1;
            if (axi_wvalid && axi_wready) w_done = 1;
            tick();
            n++;
            if (aw_done) axi_awvalid = 1'b0;
            if (w_done) axi_wvalid = 1'b0;
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        lat = 1;
        while (!axi_bvalid && lat < 20) begin tick(); lat++; end
        resp = axi_bresp;
        if (!axi_bvalid) lat = -1;
        tick();
        axi_bready = 1'b0;
    endtask

    // Full read transaction; lat = cycles from AR handshake to rvalid
    task automatic axi_read(input logic [31:0] a, output int lat, output logic [31:0] d, output logic [1:0] r);
        int n = 0;
        axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
        while (!axi_arready && n < 20) begin tick(); n++; end
        tick();
        axi_arvalid = 1'b0;
        lat = 1;
        while (!axi_rvalid && lat < 20) begin tick(); lat++; end
        d = axi_rdata; r = axi_rresp;
        if (!axi_rvalid) lat = -1;
        tick();
        axi_rready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 00000", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid});
        end
        checks++;
        if ({axi_bresp, axi_rresp, axi_rdata} !== 36'h0) begin
            errors++;
            $display("FAIL reset_data: got bresp=%b rresp=%b rdata=%h want zeros", axi_bresp, axi_rresp, axi_rdata);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL post_reset_ready: got %b want 11100", {axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid});
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen = 0;
        axi_awaddr = 32'h40; axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        checks++;
        if (axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL aw_held: got awready=%b want 0", axi_awready);
        end
        rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
        checks++;
        if ({axi_awready, axi_wready} !== 2'b11) begin
            errors++;
            $display("FAIL mid_write_ready: got %b want 11", {axi_awready, axi_wready});
        end
        // A lone W must not pair with the AW that reset discarded
        axi_wdata = 32'h0000_0BAD; axi_wstrb = 4'hF; axi_wvalid = 1'b1; axi_bready = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (axi_bvalid) seen = 1;
            tick();
        end
        axi_bready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_write_bvalid: got bvalid seen=%b want 0", seen);
        end
        rst = 1'b1; tick(); rst = 1'b0; tick();
    endtask

    task automatic test_single_write_readback();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        axi_write(32'h10, 32'hDEADBEEF, 4'hF, lat, r);
        model_write(32'h10, 32'hDEADBEEF, 4'hF);
        checks++;
        if (lat !== 2 || r !== OKAY) begin
            errors++;
            $display("FAIL write_full: got lat=%0d bresp=%b want lat=2 bresp=%b", lat, r, OKAY);
        end
        axi_write(32'h10, 32'h000000AA, 4'h1, lat, r);
        model_write(32'h10, 32'h000000AA, 4'h1);
        checks++;
        if (lat !== 2 || r !== OKAY) begin
            errors++;
            $display("FAIL write_byte: got lat=%0d bresp=%b want lat=2 bresp=%b", lat, r, OKAY);
        end
        axi_read(32'h10, lat, d, r);
        checks++;
        if (lat !== 2 || d !== model_read(32'h10) || r !== OKAY) begin
            errors++;
            $display("FAIL readback: got lat=%0d rdata=%h rresp=%b want lat=2 rdata=%h rresp=%b", lat, d, r, model_read(32'h10), OKAY);
        end
        axi_write(32'h14, 32'h11223344, 4'hF, lat, r);
        model_write(32'h14, 32'h11223344, 4'hF);
        axi_write(32'h14, 32'hFFFFFFFF, 4'h0, lat, r);
        axi_read(32'h14, lat, d, r);
        checks++;
        if (d !== model_read(32'h14) || r !== OKAY) begin
            errors++;
            $display("FAIL zero_strobe: got rdata=%h rresp=%b want rdata=%h rresp=%b", d, r, model_read(32'h14), OKAY);
        end
    endtask

    task automatic test_split_aw_w();
        bit bad = 0;
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        axi_bready = 1'b0;
        axi_wdata = 32'h12345678; axi_wstrb = 4'hF; axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        tick(); tick();
        axi_awaddr = 32'h30; axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        model_write(32'h30, 32'h12345678, 4'hF);
        checks++;
        if (axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL split_early: got bvalid=%b want 0 one cycle after AW", axi_bvalid);
        end
        tick();
        checks++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== OKAY) begin
            errors++;
            $display("FAIL split_bvalid: got bvalid=%b bresp=%b want 1 %b", axi_bvalid, axi_bresp, OKAY);
        end
        // Second pair (out of range) lands while the first response is stalled
        axi_awaddr = OOR; axi_wdata = 32'hCAFE0001; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (axi_awready || axi_wready || !axi_bvalid || axi_bresp !== OKAY) bad = 1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL b_backpressure: got stall violation=%b want 0", bad);
        end
        axi_bready = 1'b1;
        tick();
        checks++;
        if (axi_bvalid !== 1'b1 || axi_bresp !== SLV || axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL second_b: got bvalid=%b bresp=%b awready=%b want 1 %b 1", axi_bvalid, axi_bresp, axi_awready, SLV);
        end
        tick();
        axi_bready = 1'b0;
        checks++;
        if (axi_bvalid !== 1'b0) begin
            errors++;
            $display("FAIL b_drain: got bvalid=%b want 0", axi_bvalid);
        end
        axi_read(32'h30, lat, d, r);
        checks++;
        if (lat !== 2 || d !== model_read(32'h30) || r !== OKAY) begin
            errors++;
            $display("FAIL split_readback: got lat=%0d rdata=%h want lat=2 rdata=%h", lat, d, model_read(32'h30));
        end
    endtask

    task automatic test_out_of_range();
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        axi_write(32'h0, 32'h0BADF00D, 4'hF, lat, r);
        model_write(32'h0, 32'h0BADF00D, 4'hF);
        axi_write(SPAN - 32'd4, 32'h600DCAFE, 4'hF, lat, r);
        model_write(SPAN - 32'd4, 32'h600DCAFE, 4'hF);
        checks++;
        if (lat !== 2 || r !== OKAY) begin
            errors++;
            $display("FAIL last_word_write: got lat=%0d bresp=%b want 2 %b", lat, r, OKAY);
        end
        axi_write(OOR, 32'hFFFFFFFF, 4'hF, lat, r);
        checks++;
        if (lat !== 2 || r !== SLV) begin
            errors++;
            $display("FAIL oor_write: got lat=%0d bresp=%b want 2 %b", lat, r, SLV);
        end
        axi_read(OOR, lat, d, r);
        checks++;
        if (lat !== 2 || r !== SLV || d !== 32'h0) begin
            errors++;
            $display("FAIL oor_read: got lat=%0d rresp=%b rdata=%h want 2 %b 0", lat, r, d, SLV);
        end
        axi_read(32'hFFFF_FFFC, lat, d, r);
        checks++;
        if (r !== SLV || d !== 32'h0) begin
            errors++;
            $display("FAIL wrap_read: got rresp=%b rdata=%h want %b 0", r, d, SLV);
        end
        axi_read(32'h0, lat, d, r);
        checks++;
        if (d !== model_read(32'h0) || r !== OKAY) begin
            errors++;
            $display("FAIL word0_intact: got rdata=%h rresp=%b want %h %b", d, r, model_read(32'h0), OKAY);
        end
        axi_read(SPAN - 32'd4, lat, d, r);
        checks++;
        if (d !== model_read(SPAN - 32'd4) || r !== OKAY) begin
            errors++;
            $display("FAIL last_word_read: got rdata=%h rresp=%b want %h %b", d, r, model_read(SPAN - 32'd4), OKAY);
        end
    endtask

    // Issue AW, W and AR to 0x20 in the same cycle and measure both latencies
    task automatic run_conflict(input logic [31:0] d, output int blat, output int rlat, output logic [31:0] rd);
        blat = -1; rlat = -1; rd = 32'h0;
        axi_awaddr = 32'h20; axi_wdata = d; axi_wstrb = 4'hF; axi_araddr = 32'h20;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
        axi_bready = 1'b1; axi_rready = 1'b1;
        tick();
        axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (axi_bvalid && blat < 0) blat = c;
            if (axi_rvalid && rlat < 0) begin rlat = c; rd = axi_rdata; end
            tick();
        end
        axi_bready = 1'b0; axi_rready = 1'b0;
    endtask

    task automatic test_conflict();
        int lat, blat, rlat;
        logic [1:0] r;
        logic [31:0] rd, old_v, exp_v;
        bit write_wins = 1;
        axi_write(32'h20, 32'h1, 4'hF, lat, r);
        model_write(32'h20, 32'h1, 4'hF);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({axi_awready, axi_wready, axi_arready} !== 3'b111) begin
                errors++;
                $display("FAIL conflict_idle%0d: got readies=%b want 111", k, {axi_awready, axi_wready, axi_arready});
            end
            old_v = model_read(32'h20);
            run_conflict(32'h2 + k, blat, rlat, rd);
            model_write(32'h20, 32'h2 + k, 4'hF);
            exp_v = write_wins ? (32'h2 + k) : old_v;
            checks++;
            if (blat !== (write_wins ? 2 : 3) || rlat !== (write_wins ? 3 : 2) || rd !== exp_v) begin
                errors++;
                $display("FAIL conflict%0d: got blat=%0d rlat=%0d rdata=%h want %0d %0d %h", k, blat, rlat, rd,
                         write_wins ? 2 : 3, write_wins ? 3 : 2, exp_v);
            end
            write_wins = !write_wins;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [1:0] r;
        logic [31:0] d, exp_v;
        bit bad = 0;
        axi_write(32'h44, 32'h5A5A1234, 4'hF, lat, r);
        model_write(32'h44, 32'h5A5A1234, 4'hF);
        exp_v = model_read(32'h44);
        axi_araddr = 32'h44; axi_arvalid = 1'b1; axi_rready = 1'b0;
        tick();
        axi_arvalid = 1'b0;
        if (axi_arready) bad = 1;
        tick();
        // Overwrite the same word while the read response is stalled
        axi_awaddr = 32'h44; axi_wdata = 32'hFFFF0000; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!axi_rvalid || axi_rdata !== exp_v || axi_rresp !== OKAY || axi_arready) bad = 1;
            tick();
            axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        end
        model_write(32'h44, 32'hFFFF0000, 4'hF);
        checks++;
        if (bad !== 1'b0) begin
            errors++;
            $display("FAIL r_backpressure: got stability violation=%b want 0 (rdata=%h expect %h)", bad, axi_rdata, exp_v);
        end
        axi_rready = 1'b1;
        checks++;
        if (axi_rvalid !== 1'b1 || axi_rdata !== exp_v) begin
            errors++;
            $display("FAIL r_release: got rvalid=%b rdata=%h want 1 %h", axi_rvalid, axi_rdata, exp_v);
        end
        tick();
        axi_rready = 1'b0; axi_bready = 1'b0;
        checks++;
        if (axi_arready !== 1'b1 || axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL r_after: got arready=%b rvalid=%b want 1 0", axi_arready, axi_rvalid);
        end
        axi_read(32'h44, lat, d, r);
        checks++;
        if (lat !== 2 || d !== model_read(32'h44)) begin
            errors++;
            $display("FAIL bp_readback: got lat=%0d rdata=%h want 2 %h", lat, d, model_read(32'h44));
        end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0] r;
        logic [31:0] a, d, rd;
        logic [3:0] s;
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            axi_write(32'h100 + 32'(i * 4), d, 4'hF, lat, r);
            model_write(32'h100 + 32'(i * 4), d, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, lat, r);
                if (lat !== 2 || r !== model_resp(a)) begin
                    bad++;
                    $display("FAIL rnd_write: addr=%h got lat=%0d bresp=%b want 2 %b", a, lat, r, model_resp(a));
                end
                model_write(a, d, s);
            end else begin
                axi_read(a, lat, rd, r);
                if (lat !== 2 || r !== model_resp(a) || rd !== model_read(a)) begin
                    bad++;
                    $display("FAIL rnd_read: addr=%h got lat=%0d rresp=%b rdata=%h want 2 %b %h", a, lat, r, rd, model_resp(a), model_read(a));
                end
            end
            checks++;
        end
        errors += bad;
    endtask

    task automatic test_back_to_back();
        int hs_t[$];
        logic [31:0] got[$];
        int k = 0;
        int nb = 0;
        bit ok;
        int lat;
        logic [1:0] r;
        logic [31:0] d;
        axi_rready = 1'b1; axi_araddr = 32'h100; axi_arvalid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            bit hs;
            hs = axi_arvalid && axi_arready;
            if (hs) begin hs_t.push_back(c); k++; end
            if (axi_rvalid) got.push_back(axi_rdata);
            tick();
            if (hs) axi_araddr = 32'h100 + 32'(k * 4);
        end
        axi_arvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (axi_rvalid) got.push_back(axi_rdata);
            tick();
        end
        axi_rready = 1'b0;
        ok = (hs_t.size() == 4) && (got.size() == 4);
        if (ok) for (int i = 0; i < 4; i++) if (hs_t[i] != 3 * i || got[i] !== model_read(32'h100 + 32'(i * 4))) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_read: got %0d issues %0d responses, want 4 issues every 3 cycles with model data", hs_t.size(), got.size());
        end
        hs_t.delete();
        k = 0;
        axi_bready = 1'b1; axi_awaddr = 32'h180; axi_wdata = 32'hA0000000; axi_wstrb = 4'hF;
        axi_awvalid = 1'b1; axi_wvalid = 1'b1;
        for (int c = 0; c < 11; c++) begin
            bit hs;
            hs = axi_awvalid && axi_awready && axi_wvalid && axi_wready;
            if (axi_bvalid) nb++;
            if (hs) begin hs_t.push_back(c); model_write(axi_awaddr, axi_wdata, 4'hF); k++; end
            tick();
            if (hs) begin axi_awaddr = 32'h180 + 32'(k * 4); axi_wdata = 32'hA0000000 + 32'(k); end
            if (c == 7) begin axi_awvalid = 1'b0; axi_wvalid = 1'b0; end
        end
        axi_bready = 1'b0;
        ok = (hs_t.size() == 4) && (nb == 4);
        if (ok) for (int i = 0; i < 4; i++) if (hs_t[i] != 2 * i) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_write: got %0d issues %0d responses, want 4 issues every 2 cycles and 4 responses", hs_t.size(), nb);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(32'h180 + 32'(i * 4), lat, d, r);
            checks++;
            if (d !== model_read(32'h180 + 32'(i * 4))) begin
                errors++;
                $display("FAIL b2b_readback%0d: got %h want %h", i, d, model_read(32'h180 + 32'(i * 4)));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        axi_awaddr = 32'h0; axi_awvalid = 1'b0; axi_awprot = 3'b000;
        axi_wdata = 32'h0; axi_wstrb = 4'h0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        axi_araddr = 32'h0; axi_arvalid = 1'b0; axi_arprot = 3'b000; axi_rready = 1'b0;
        test_reset();
        test_reset_mid_write();
        test_single_write_readback();
        test_split_aw_w();
        test_out_of_range();
        test_conflict();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
